pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Front-end program-counter controller that sequences fetch around branch redirects. Owns the architectural fetch PC and advances it on accepted fetches. On a redirect from the branch unit it drives a timed pipeline-flush window, then restarts fetch at the redirect target. Sits between the branch unit's redirect/flush outputs and the fetch stage.

Parameters:
PC_WIDTH, 16, width of all PC values
FLUSH_CYCLES, 3, cycles flush_o stays high per accepted redirect (legal range 1..15)
RESET_PC, 0, PC value loaded at reset

Ports:
clock_i  in  1  rising-edge clock
reset_i  in  1  synchronous, active-low reset
stall_i  in  1  pipeline stalled; PC must not advance
fetchAck_i  in  1  fetch stage consumed pc_o this cycle
redirect_i  in  1  branch unit requests redirect (one-cycle pulse)
redirectPc_i  in  PC_WIDTH  redirect target, valid with redirect_i
pc_o  out  PC_WIDTH  current fetch PC
pcValid_o  out  1  pc_o may be fetched
flush_o  out  1  kill all in-flight pipeline stages
state_o  out  2  00 RUN, 01 FLUSH, 10 RESUME
redirectCount_o  out  8  accepted redirects, saturating at 255

Behaviour:
- Interface: one clock, clock_i; reset_i is synchronous and active-low. All outputs registered.
- Reset (reset_i=0 at a rising edge): pc_o=RESET_PC, pcValid_o=0, flush_o=0, state_o=RESUME, redirectCount_o=0, flush counter=0. Reset wins over every other input in any state, including mid-flush.
- RUN: pcValid_o=1, flush_o=0.
  - fetchAck_i=1 and stall_i=0: pc_o <= pc_o+1, modulo 2^PC_WIDTH (all-ones wraps to 0).
  - stall_i=1: pc_o holds regardless of fetchAck_i.
  - redirect_i=1: takes priority over increment and over stall.
    - Next cycle: pc_o=redirectPc_i, flush_o=1, pcValid_o=0, counter=FLUSH_CYCLES-1, redirectCount_o increments unless already 255, state FLUSH.
- FLUSH: flush_o=1, pcValid_o=0, pc_o holds the target.
  - Counter decrements every cycle; stall_i does not pause it.
  - When counter=0, next state is RESUME with flush_o=0.
  - flush_o is therefore high for exactly FLUSH_CYCLES consecutive cycles.
  - redirect_i during FLUSH comes from wrong-path instructions: discarded, target and count unchanged.
  - fetchAck_i is ignored.
- RESUME: flush_o=0, pcValid_o=0.
  - stall_i=0: next state RUN, with pcValid_o=1 and pc_o unchanged.
  - stall_i=1: remain in RESUME.
  - redirect_i=1: accepted exactly as in RUN, re-entering FLUSH with the new target.
- Latency: redirect_i at edge N gives flush_o=1 from edge N+1 to N+FLUSH_CYCLES and pcValid_o=1 at edge N+FLUSH_CYCLES+2 if unstalled.
- Invariant: flush_o and pcValid_o are never both 1.

Test Plan:
- Reset, then release with stall_i=0 and fetchAck_i=1 for 4 cycles -> RESUME for 1 cycle, then pc_o 0,1,2,3 with pcValid_o=1.
- In RUN at pc_o=0x0010, redirect_i=1 with redirectPc_i=0x0040 (FLUSH_CYCLES=3) -> flush_o high exactly 3 cycles, pc_o=0x0040, 1 RESUME cycle, then pcValid_o=1, redirectCount_o=1.
- During FLUSH, second redirect_i to 0x0080 -> ignored; restart at 0x0040, redirectCount_o stays 1.
- pc_o=0xFFFF, fetchAck_i=1, stall_i=0 -> pc_o=0x0000. With stall_i=1 and fetchAck_i=1 -> pc_o holds.
- redirect_i and fetchAck_i in the same RUN cycle while stall_i=1 -> redirect taken, no increment. Hold stall_i=1 through RESUME -> stays in RESUME until stall_i drops.
- Assert reset_i=0 mid-FLUSH -> next edge pc_o=RESET_PC, flush_o=0, state_o=RESUME, redirectCount_o=0. Apply 260 redirects -> redirectCount_o saturates at 255.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: owns the fetch PC, advances it on accepted
// fetches, and on a branch redirect runs a fixed-length flush window before restarting.
module pc_sequencer #(
  parameter int                    PC_WIDTH     = 16,
  parameter int                    FLUSH_CYCLES = 3,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                stall_i,
  input  logic                fetchAck_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirectPc_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                pcValid_o,
  output logic                flush_o,
  output logic [1:0]          state_o,
  output logic [7:0]          redirectCount_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_RESUME = 2'b10
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                pc_valid_q;
  logic                flush_q;
  logic [3:0]          flush_cnt_q;
  logic [7:0]          redirect_cnt_q;

  // Redirects arriving while flushing belong to wrong-path instructions and are dropped.
  logic redirect_accept;
  assign redirect_accept = redirect_i && (state_q != ST_FLUSH);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q        <= ST_RESUME;
      pc_q           <= RESET_PC;
      pc_valid_q     <= 1'b0;
      flush_q        <= 1'b0;
      flush_cnt_q    <= 4'd0;
      redirect_cnt_q <= 8'd0;
    end else if (redirect_accept) begin
      state_q     <= ST_FLUSH;
      pc_q        <= redirectPc_i;
      pc_valid_q  <= 1'b0;
      flush_q     <= 1'b1;
      flush_cnt_q <= FLUSH_LAST;
      if (redirect_cnt_q != 8'hFF) begin
        redirect_cnt_q <= redirect_cnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          pc_valid_q <= 1'b1;
          flush_q    <= 1'b0;
          if (fetchAck_i && !stall_i) begin
            pc_q <= pc_q + PC_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          // The flush window is time-based: stall does not extend it.
          if (flush_cnt_q == 4'd0) begin
            state_q <= ST_RESUME;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        ST_RESUME: begin
          flush_q <= 1'b0;
          if (!stall_i) begin
            state_q    <= ST_RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_RESUME;
          pc_valid_q <= 1'b0;
          flush_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o            = pc_q;
  assign pcValid_o       = pc_valid_q;
  assign flush_o         = flush_q;
  assign state_o         = state_q;
  assign redirectCount_o = redirect_cnt_q;

endmodule
